// File: rtl/pcnt_pkg.sv
// Shared definitions for the pulse-counter scan stream (sequencer and receiver).
package pcnt_pkg;

   localparam int unsigned CH_W       = 3;
   localparam int unsigned DATA_W_DEF = 10;
   localparam int unsigned NUM_CH_DEF = 6;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } rx_state_e;

   // Increment that sticks at the given ceiling.
   function automatic logic [CH_W-1:0] sat_inc(input logic [CH_W-1:0] val,
                                               input logic [CH_W-1:0] ceil);
      return (val >= ceil) ? val : val + 1'b1;
   endfunction

endpackage

// File: rtl/rx_out_reg.sv
// Single-entry valid/ready holding register for received words.
// A commit loads when the entry is free or being drained this cycle; otherwise it is
// refused and reported as an overrun, leaving the held word untouched.
module rx_out_reg
   import pcnt_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              commit,
   input  logic [DATA_W-1:0] commit_data,
   input  logic [CH_W-1:0]   commit_ch,
   input  logic              word_ready,
   output logic [DATA_W-1:0] word_data,
   output logic [CH_W-1:0]   word_ch,
   output logic              word_valid,
   output logic              commit_ok,
   output logic              commit_ovr
);

   logic [DATA_W-1:0] data_q;
   logic [CH_W-1:0]   ch_q;
   logic              valid_q;
   logic              accept;

   // Handshake decode: drain, successful load, or refused load.
   always_comb begin
      accept     = valid_q & word_ready;
      commit_ok  = commit & (~valid_q | accept);
      commit_ovr = commit & valid_q & ~word_ready;
   end

   // Holding register; a load in the same cycle as a drain keeps valid high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
      end else if (commit_ok) begin
         data_q  <= commit_data;
         ch_q    <= commit_ch;
         valid_q <= 1'b1;
      end else if (accept) begin
         valid_q <= 1'b0;
      end
   end

   assign word_data  = data_q;
   assign word_ch    = ch_q;
   assign word_valid = valid_q;

endmodule

// File: rtl/scan_slot_rx.sv
// Scan stream slot receiver: rebuilds each serial slot (sl strobe + MSB-first count)
// into a channel-tagged parallel word, tracks slots per scan, flags framing/overrun.
module scan_slot_rx
   import pcnt_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NUM_CH = NUM_CH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              sl,
   input  logic              sdi,
   input  logic [CH_W-1:0]   ch_addr,
   input  logic              scan_done,
   output logic [DATA_W-1:0] word_data,
   output logic [CH_W-1:0]   word_ch,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              frame_done,
   output logic [CH_W-1:0]   slot_cnt,
   output logic              err_frame,
   output logic              err_ovr,
   input  logic              err_clr
);

   localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CH_W-1:0]  SLOT_MAX = CH_W'(NUM_CH);

   rx_state_e         state_q, state_d;
   logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CH_W-1:0]   slot_cnt_q, slot_cnt_d;
   logic              frame_done_q, frame_done_d;
   logic              err_frame_q, err_frame_d;
   logic              err_ovr_q, err_ovr_d;

   logic [DATA_W-1:0] shifted;
   logic              commit;
   logic              frame_evt;
   logic              commit_ok;
   logic              commit_ovr;

   assign shifted = {shreg_q[DATA_W-2:0], sdi};

   // Slot FSM: start on sl, shift DATA_W bits, commit on the last one.
   always_comb begin
      state_d   = state_q;
      cur_ch_d  = cur_ch_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      commit    = 1'b0;
      frame_evt = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tick && sl) begin
               cur_ch_d  = ch_addr;
               shreg_d   = '0;
               bit_cnt_d = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (tick) begin
               if (sl) begin
                  // Early strobe: drop the partial word; scan end takes us out entirely.
                  frame_evt = 1'b1;
                  if (scan_done) begin
                     state_d = StIdle;
                  end else begin
                     cur_ch_d  = ch_addr;
                     shreg_d   = '0;
                     bit_cnt_d = '0;
                  end
               end else if (bit_cnt_q == LAST_BIT) begin
                  // Completing bit wins over a coincident scan end.
                  shreg_d = shifted;
                  commit  = 1'b1;
                  state_d = StIdle;
               end else if (scan_done) begin
                  frame_evt = 1'b1;
                  state_d   = StIdle;
               end else begin
                  shreg_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Per-scan counters and sticky errors; a set event beats err_clr.
   always_comb begin
      slot_cnt_d   = slot_cnt_q;
      frame_done_d = tick & scan_done;
      if (tick && scan_done) begin
         slot_cnt_d = '0;
      end else if (commit_ok) begin
         slot_cnt_d = sat_inc(slot_cnt_q, SLOT_MAX);
      end
      err_frame_d = frame_evt | (err_frame_q & ~err_clr);
      err_ovr_d   = commit_ovr | (err_ovr_q & ~err_clr);
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cur_ch_q     <= '0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         slot_cnt_q   <= '0;
         frame_done_q <= 1'b0;
         err_frame_q  <= 1'b0;
         err_ovr_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_ch_q     <= cur_ch_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         slot_cnt_q   <= slot_cnt_d;
         frame_done_q <= frame_done_d;
         err_frame_q  <= err_frame_d;
         err_ovr_q    <= err_ovr_d;
      end
   end

   rx_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk         (clk),
      .reset       (reset),
      .commit      (commit),
      .commit_data (shifted),
      .commit_ch   (cur_ch_q),
      .word_ready  (word_ready),
      .word_data   (word_data),
      .word_ch     (word_ch),
      .word_valid  (word_valid),
      .commit_ok   (commit_ok),
      .commit_ovr  (commit_ovr)
   );

   assign frame_done = frame_done_q;
   assign slot_cnt   = slot_cnt_q;
   assign err_frame  = err_frame_q;
   assign err_ovr    = err_ovr_q;

endmodule

// File: tb/tb_scan_slot_rx.sv
// Bench for scan_slot_rx: slot-level reference model checked every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_scan_slot_rx;

   localparam int DW  = 10;
   localparam int NCH = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tick = 1'b0;
   logic          sl = 1'b0;
   logic          sdi = 1'b0;
   logic [2:0]    ch_addr = 3'd0;
   logic          scan_done = 1'b0;
   logic          word_ready = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] word_data;
   logic [2:0]    word_ch;
   logic          word_valid;
   logic          frame_done;
   logic [2:0]    slot_cnt;
   logic          err_frame;
   logic          err_ovr;

   int total = 0;
   int bad   = 0;
   int got_q[$];   // accepted words as (ch << 16) | data

   scan_slot_rx #(
      .DATA_W (DW),
      .NUM_CH (NCH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .sl         (sl),
      .sdi        (sdi),
      .ch_addr    (ch_addr),
      .scan_done  (scan_done),
      .word_data  (word_data),
      .word_ch    (word_ch),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_done (frame_done),
      .slot_cnt   (slot_cnt),
      .err_frame  (err_frame),
      .err_ovr    (err_ovr),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: slot bits collected in a queue, output entry as plain variables.
   int m_valid, m_data, m_wch, m_cnt, m_fd, m_ef, m_eo;
   int m_in_slot, m_ch, m_acc, m_commit, m_fe, m_ovr, m_word;
   bit m_bits[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid = 0; m_data = 0; m_wch = 0; m_cnt = 0; m_fd = 0; m_ef = 0; m_eo = 0;
         m_in_slot = 0; m_ch = 0; m_bits.delete();
      end else begin
         m_acc    = (m_valid != 0 && word_ready) ? 1 : 0;
         m_commit = 0;
         m_fe     = 0;
         m_ovr    = 0;
         if (tick) begin
            if (m_in_slot == 0) begin
               if (sl) begin
                  m_in_slot = 1;
                  m_ch      = int'(ch_addr);
                  m_bits.delete();
               end
            end else if (sl) begin
               m_fe = 1;
               m_bits.delete();
               if (scan_done) m_in_slot = 0;
               else m_ch = int'(ch_addr);
            end else begin
               m_bits.push_back(sdi);
               if (m_bits.size() == DW) begin
                  m_commit = 1;
                  m_word   = 0;
                  foreach (m_bits[k]) m_word = (m_word << 1) | int'(m_bits[k]);
                  m_bits.delete();
                  m_in_slot = 0;
               end else if (scan_done) begin
                  m_fe      = 1;
                  m_in_slot = 0;
                  m_bits.delete();
               end
            end
         end
         if (m_commit != 0 && (m_valid == 0 || m_acc != 0)) begin
            m_data  = m_word;
            m_wch   = m_ch;
            m_valid = 1;
            if (m_cnt < NCH) m_cnt++;
         end else begin
            if (m_commit != 0) m_ovr = 1;
            if (m_acc != 0) m_valid = 0;
         end
         if (tick && scan_done) m_cnt = 0;
         m_fd = (tick && scan_done) ? 1 : 0;
         m_ef = (m_fe != 0 || (m_ef != 0 && !err_clr)) ? 1 : 0;
         m_eo = (m_ovr != 0 || (m_eo != 0 && !err_clr)) ? 1 : 0;
      end
   end

   // Compare every cycle away from the active edge; log accepted words.
   always @(negedge clk) begin
      if (!reset) begin
         chk("word_valid", 32'(word_valid), 32'(m_valid));
         chk("word_data", 32'(word_data), 32'(m_data));
         chk("word_ch", 32'(word_ch), 32'(m_wch));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         chk("slot_cnt", 32'(slot_cnt), 32'(m_cnt));
         chk("err_frame", 32'(err_frame), 32'(m_ef));
         chk("err_ovr", 32'(err_ovr), 32'(m_eo));
         if (word_valid && word_ready) got_q.push_back((int'(word_ch) << 16) | int'(word_data));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_tick(input logic s, input logic d, input logic [2:0] a,
                            input logic dn, input int gap);
      tick = 1'b1; sl = s; sdi = d; ch_addr = a; scan_done = dn;
      cyc();
      tick = 1'b0; sl = 1'b0; sdi = 1'b0; scan_done = 1'b0;
      repeat (gap) cyc();
   endtask

   // rdy_last >= 0 forces word_ready during the final data tick.
   task automatic send_slot(input logic [2:0] a, input logic [31:0] d, input int gap,
                            input int rdy_last);
      send_tick(1'b1, 1'b0, a, 1'b0, gap);
      for (int i = DW - 1; i >= 0; i--) begin
         if (i == 0 && rdy_last >= 0) word_ready = (rdy_last != 0);
         send_tick(1'b0, d[i], 3'd0, 1'b0, gap);
      end
   endtask

   task automatic chk_got(input string name, input int idx, input int ch, input int data);
      if (got_q.size() > idx) chk(name, 32'(got_q[idx]), 32'((ch << 16) | data));
      else chk({name, " missing"}, 32'(got_q.size()), 32'(idx + 1));
   endtask

   initial begin
      logic [DW-1:0] pat;
      int addrs[6];
      addrs = '{0, 4, 0, 1, 2, 3};

      // Reset values
      repeat (2) cyc();
      chk("rst word_valid", 32'(word_valid), 0);
      chk("rst word_data", 32'(word_data), 0);
      chk("rst slot_cnt", 32'(slot_cnt), 0);
      chk("rst errors", 32'({err_frame, err_ovr, frame_done}), 0);
      reset = 1'b0;
      cyc();

      // Single slot, tick every 3 clk
      word_ready = 1'b1;
      got_q.delete();
      pat = 10'b1011001110;
      send_tick(1'b1, 1'b0, 3'd4, 1'b0, 2);
      for (int i = DW - 1; i >= 1; i--) send_tick(1'b0, pat[i], 3'd0, 1'b0, 2);
      chk("single pre-valid", 32'(word_valid), 0);
      send_tick(1'b0, pat[0], 3'd0, 1'b0, 0);
      chk("single valid rise", 32'(word_valid), 1);
      chk("single data", 32'(word_data), 32'h2CE);
      chk("single ch", 32'(word_ch), 4);
      cyc();
      chk("single valid fall", 32'(word_valid), 0);
      chk_got("single got", 0, 4, 'h2CE);
      send_tick(1'b0, 1'b0, 3'd0, 1'b1, 2);

      // Full scan
      got_q.delete();
      for (int s = 0; s < 6; s++) send_slot(3'(addrs[s]), 32'(s + 1), 2, -1);
      cyc();
      chk("scan slot_cnt", 32'(slot_cnt), 6);
      chk("scan words", 32'(got_q.size()), 6);
      for (int s = 0; s < 6; s++) chk_got("scan word", s, addrs[s], s + 1);
      send_tick(1'b0, 1'b0, 3'd0, 1'b1, 0);
      chk("scan frame_done", 32'(frame_done), 1);
      chk("scan slot_cnt clr", 32'(slot_cnt), 0);
      cyc();
      chk("scan frame_done pulse", 32'(frame_done), 0);

      // Backpressure: second word dropped, first held
      word_ready = 1'b0;
      got_q.delete();
      send_slot(3'd1, 32'h155, 1, -1);
      send_slot(3'd2, 32'h0AA, 1, -1);
      cyc();
      chk("bp valid", 32'(word_valid), 1);
      chk("bp data held", 32'(word_data), 32'h155);
      chk("bp ch held", 32'(word_ch), 1);
      chk("bp err_ovr", 32'(err_ovr), 1);
      chk("bp slot_cnt", 32'(slot_cnt), 1);
      word_ready = 1'b1;
      cyc();
      chk("bp drained", 32'(word_valid), 0);
      chk("bp words", 32'(got_q.size()), 1);
      chk_got("bp got", 0, 1, 'h155);
      chk("bp err_ovr sticky", 32'(err_ovr), 1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("bp err_clr", 32'(err_ovr), 0);
      send_tick(1'b0, 1'b0, 3'd0, 1'b1, 1);

      // Continuous tick, commit coinciding with acceptance
      word_ready = 1'b0;
      got_q.delete();
      send_slot(3'd3, 32'h123, 0, -1);
      send_slot(3'd5, 32'h2AB, 0, 1);
      send_slot(3'd6, 32'h001, 0, -1);
      repeat (3) cyc();
      chk("cont words", 32'(got_q.size()), 3);
      chk_got("cont w0", 0, 3, 'h123);
      chk_got("cont w1", 1, 5, 'h2AB);
      chk_got("cont w2", 2, 6, 'h001);
      chk("cont err_ovr", 32'(err_ovr), 0);
      send_tick(1'b0, 1'b0, 3'd0, 1'b1, 1);

      // Framing: sl after 5 data bits
      got_q.delete();
      send_tick(1'b1, 1'b0, 3'd7, 1'b0, 1);
      for (int i = 0; i < 5; i++) send_tick(1'b0, 1'(i % 2), 3'd0, 1'b0, 1);
      send_slot(3'd2, 32'h3FF, 1, -1);
      cyc();
      chk("frame err_frame", 32'(err_frame), 1);
      chk("frame words", 32'(got_q.size()), 1);
      chk_got("frame got", 0, 2, 'h3FF);

      // Reset mid-slot
      send_tick(1'b1, 1'b0, 3'd6, 1'b0, 1);
      for (int i = 0; i < 4; i++) send_tick(1'b0, 1'b1, 3'd0, 1'b0, 1);
      reset = 1'b1;
      cyc();
      chk("mid rst word_valid", 32'(word_valid), 0);
      chk("mid rst word_data", 32'(word_data), 0);
      chk("mid rst word_ch", 32'(word_ch), 0);
      chk("mid rst slot_cnt", 32'(slot_cnt), 0);
      chk("mid rst err_frame", 32'(err_frame), 0);
      chk("mid rst err_ovr", 32'(err_ovr), 0);
      chk("mid rst frame_done", 32'(frame_done), 0);
      reset = 1'b0;
      cyc();
      got_q.delete();
      send_slot(3'd2, 32'h0F0, 1, -1);
      repeat (2) cyc();
      chk("post rst words", 32'(got_q.size()), 1);
      chk_got("post rst got", 0, 2, 'h0F0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
